// File: rtl/game_autoplayer.sv
// Automated player for the LED memory game: presses the start chord, records each
// displayed LED pattern and replays it as timed switch presses.
module game_autoplayer #(
  parameter int CLKS_PER_SEC = 25000000,
  parameter int PRESS_CLKS   = CLKS_PER_SEC / 10,
  parameter int GAP_CLKS     = CLKS_PER_SEC / 10,
  parameter int IDLE_CLKS    = CLKS_PER_SEC / 2,
  parameter int MAX_LEN      = 11
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Start,
  input  logic       i_LED_1,
  input  logic       i_LED_2,
  input  logic       i_LED_3,
  input  logic       i_LED_4,
  output logic       o_Switch_1,
  output logic       o_Switch_2,
  output logic       o_Switch_3,
  output logic       o_Switch_4,
  output logic       o_Busy,
  output logic       o_Error,
  output logic [7:0] o_Rounds,
  output logic [3:0] o_Seq_Len
);

  localparam int MAX_PG   = (PRESS_CLKS > GAP_CLKS) ? PRESS_CLKS : GAP_CLKS;
  localparam int MAX_CLKS = (MAX_PG > IDLE_CLKS) ? MAX_PG : IDLE_CLKS;
  localparam int TW       = $clog2(MAX_CLKS + 1);

  localparam logic [TW-1:0] PRESS_LAST = TW'(PRESS_CLKS - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CLKS - 1);
  localparam logic [TW-1:0] IDLE_LAST  = TW'(IDLE_CLKS - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
  localparam logic [3:0]    LEN_FULL   = 4'(MAX_LEN);

  typedef enum logic [2:0] {
    IDLE,
    START_PRESS,
    START_GAP,
    LISTEN,
    PLAY_PRESS,
    PLAY_GAP,
    ERROR
  } state_t;

  state_t        state;
  logic [3:0]    r_led;
  logic [3:0]    r_led_prev;
  logic [TW-1:0] timer;
  logic [3:0]    seq_len;
  logic [3:0]    play_idx;
  logic [1:0]    seq_mem [16];
  logic [3:0]    switches;
  logic          busy;
  logic          error;
  logic [7:0]    rounds;

  logic          led_rise;
  logic          led_multi;
  logic [1:0]    led_id;
  logic [3:0]    next_idx;

  // A new entry is a clean 0000 -> one-hot step; any change onto 2+ lit LEDs is illegal.
  always_comb begin
    led_rise  = (r_led_prev == 4'b0000) && $onehot(r_led);
    led_multi = (r_led != r_led_prev) && !$onehot0(r_led);
    next_idx  = play_idx + 4'd1;
    led_id    = 2'd0;
    case (r_led)
      4'b0010: led_id = 2'd1;
      4'b0100: led_id = 2'd2;
      4'b1000: led_id = 2'd3;
      default: led_id = 2'd0;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    r_led      <= {i_LED_4, i_LED_3, i_LED_2, i_LED_1};
    r_led_prev <= r_led;
    if (i_Reset) begin
      state    <= IDLE;
      switches <= 4'b0000;
      busy     <= 1'b0;
      error    <= 1'b0;
      rounds   <= 8'd0;
      seq_len  <= 4'd0;
      play_idx <= 4'd0;
      timer    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_Start) begin
            state    <= START_PRESS;
            switches <= 4'b0011;
            busy     <= 1'b1;
            rounds   <= 8'd0;
            seq_len  <= 4'd0;
            timer    <= '0;
          end
        end
        START_PRESS: begin
          if (timer == PRESS_LAST) begin
            state    <= START_GAP;
            switches <= 4'b0000;
            timer    <= '0;
          end else begin
            timer <= timer + TIMER_ONE;
          end
        end
        START_GAP: begin
          if (timer == GAP_LAST) begin
            state <= LISTEN;
            timer <= '0;
          end else begin
            timer <= timer + TIMER_ONE;
          end
        end
        LISTEN: begin
          if (led_multi || (led_rise && seq_len == LEN_FULL)) begin
            state <= ERROR;
            busy  <= 1'b0;
            error <= 1'b1;
          end else begin
            if (led_rise) begin
              seq_mem[seq_len] <= led_id;
              seq_len          <= seq_len + 4'd1;
            end
            // The end-of-pattern window only runs once something has been recorded.
            if (r_led != 4'b0000) begin
              timer <= '0;
            end else if (seq_len != 4'd0) begin
              if (timer == IDLE_LAST) begin
                state    <= PLAY_PRESS;
                timer    <= '0;
                play_idx <= 4'd0;
                switches <= 4'b0001 << seq_mem[0];
              end else begin
                timer <= timer + TIMER_ONE;
              end
            end
          end
        end
        PLAY_PRESS: begin
          if (timer == PRESS_LAST) begin
            state    <= PLAY_GAP;
            switches <= 4'b0000;
            timer    <= '0;
          end else begin
            timer <= timer + TIMER_ONE;
          end
        end
        PLAY_GAP: begin
          if (timer == GAP_LAST) begin
            timer <= '0;
            if (play_idx == seq_len - 4'd1) begin
              state   <= LISTEN;
              seq_len <= 4'd0;
              if (rounds != 8'hFF) rounds <= rounds + 8'd1;
            end else begin
              state    <= PLAY_PRESS;
              play_idx <= next_idx;
              switches <= 4'b0001 << seq_mem[next_idx];
            end
          end else begin
            timer <= timer + TIMER_ONE;
          end
        end
        ERROR: begin
          switches <= 4'b0000;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_Switch_1 = switches[0];
  assign o_Switch_2 = switches[1];
  assign o_Switch_3 = switches[2];
  assign o_Switch_4 = switches[3];
  assign o_Busy     = busy;
  assign o_Error    = error;
  assign o_Rounds   = rounds;
  assign o_Seq_Len  = seq_len;

endmodule
